// File: rtl/rsa_word_serializer.sv
// Serializes one DATA_W-bit RSA operand into WORD_W-bit words with valid/index/last and a hold stall.
// Build option SERIAL_MSW_FIRST_EN: emit the most-significant word first (default is LSW first).
module rsa_word_serializer #(
    parameter int DATA_W = 512,
    parameter int WORD_W = 32,
    localparam int WORDS = DATA_W / WORD_W,
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              hold,
    output logic [WORD_W-1:0] data_out,
    output logic              word_vld,
    output logic [IW-1:0]     word_idx,
    output logic              last,
    output logic              busy
);

    // state | meaning
    // IDLE  | no stream; outputs parked at zero
    // SHIFT | stream in progress; data_out holds word word_idx
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sr, sr_nxt;
    logic [WORD_W-1:0] dout_nxt;
    logic [IW-1:0]     idx_nxt;

    // The shift register holds only the words not yet moved into data_out.
    function automatic logic [WORD_W-1:0] head(input logic [DATA_W-1:0] v);
`ifdef SERIAL_MSW_FIRST_EN
        return v[DATA_W-1 -: WORD_W];
`else
        return v[WORD_W-1:0];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
`ifdef SERIAL_MSW_FIRST_EN
        return v << WORD_W;
`else
        return v >> WORD_W;
`endif
    endfunction

    assign busy     = (state == SHIFT);
    assign word_vld = busy & ~hold;
    assign last     = word_vld & (word_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            sr       <= '0;
            data_out <= '0;
            word_idx <= '0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            data_out <= dout_nxt;
            word_idx <= idx_nxt;
        end
    end

    // load takes priority over everything, including hold and the final word.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        dout_nxt  = data_out;
        idx_nxt   = word_idx;
        if (load) begin
            state_nxt = SHIFT;
            sr_nxt    = advance(data_in);
            dout_nxt  = head(data_in);
            idx_nxt   = '0;
        end else if (word_vld) begin
            if (word_idx == IDX_LAST) begin
                state_nxt = IDLE;
                sr_nxt    = '0;
                dout_nxt  = '0;
                idx_nxt   = '0;
            end else begin
                sr_nxt   = advance(sr);
                dout_nxt = head(sr);
                idx_nxt  = word_idx + IW'(1);
            end
        end
    end

endmodule
